// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache responder: state encodings, geometry
// derivation and address field helpers.
package dcache_pkg;

  localparam int unsigned DEF_LINES      = 64;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LANES          = 4;
  // Helpers work on a widened address so one function serves any ADDR_WIDTH.
  localparam int unsigned ADDR_MAX       = 64;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_FILL_REQ  = 3'd1;
  localparam logic [2:0] ENC_FILL_WAIT = 3'd2;
  localparam logic [2:0] ENC_FILL_DONE = 3'd3;
  localparam logic [2:0] ENC_WR_REQ    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_FILL_REQ  = ENC_FILL_REQ,
    ST_FILL_WAIT = ENC_FILL_WAIT,
    ST_FILL_DONE = ENC_FILL_DONE,
    ST_WR_REQ    = ENC_WR_REQ
  } state_e;

  function automatic int unsigned offset_width(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned index_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  // Two byte-select bits sit below the word offset.
  function automatic int unsigned tag_width(input int unsigned addr_width,
                                            input int unsigned lines,
                                            input int unsigned line_words);
    return addr_width - $clog2(lines) - $clog2(line_words) - 2;
  endfunction

  function automatic logic [ADDR_MAX-1:0] addr_field(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned lsb,
                                                     input int unsigned width);
    logic [ADDR_MAX-1:0] mask;
    mask = (width >= ADDR_MAX) ? '1 : ((64'd1 << width) - 64'd1);
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic [ADDR_MAX-1:0] line_align(input logic [ADDR_MAX-1:0] addr,
                                                     input int unsigned offset_w);
    logic [ADDR_MAX-1:0] mask;
    mask = (64'd1 << (offset_w + 2)) - 64'd1;
    return addr & ~mask;
  endfunction

  function automatic logic [ADDR_MAX-1:0] word_align(input logic [ADDR_MAX-1:0] addr);
    return {addr[ADDR_MAX-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/dcache_data_array.sv
// Cache data storage: one byte-enabled write port and a registered read port
// whose output holds its value when no read is requested.
module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic [LANES-1:0]  wr_be,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_q, rd_data_d;

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_be[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  // Next read value: a new word when asked, otherwise hold the last one.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  // Read output register; only this register is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | serve hits, decode new reads/writes
// FILL_REQ  | line read request presented, waiting for mem_req_ready
// FILL_WAIT | collecting line beats into the data array
// FILL_DONE | line installed; read the requested word, release stall
// WR_REQ    | write-through request presented, waiting for mem_req_ready
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dcache_addr,
  input  logic [3:0]            dcache_we,
  input  logic                  dcache_re,
  input  logic [31:0]           dcache_din,
  output logic [31:0]           dcache_dout,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_rnw,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [31:0]           mem_req_data,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_resp_valid,
  input  logic [31:0]           mem_resp_data
);

  localparam int unsigned OFFSET_W = offset_width(LINE_WORDS);
  localparam int unsigned INDEX_W  = index_width(LINES);
  localparam int unsigned TAG_W    = tag_width(ADDR_WIDTH, LINES, LINE_WORDS);
  localparam int unsigned ARR_AW   = INDEX_W + OFFSET_W;
  localparam int unsigned TAG_LSB  = 2 + OFFSET_W + INDEX_W;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  state_e                state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_mem [LINES];
  logic [OFFSET_W-1:0]   beat_q, beat_d;
  logic                  wr_done_q, wr_done_d;
  logic                  mem_req_valid_q, mem_req_valid_d;
  logic                  mem_req_rnw_q, mem_req_rnw_d;
  logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
  logic [31:0]           mem_req_data_q, mem_req_data_d;
  logic [3:0]            mem_req_be_q, mem_req_be_d;

  logic [OFFSET_W-1:0]   cur_offset;
  logic [INDEX_W-1:0]    cur_index, fill_index;
  logic [TAG_W-1:0]      cur_tag, fill_tag;
  logic                  hit, is_write, is_read;
  logic                  tag_we, arr_rd_en;
  logic [3:0]            arr_wr_be;
  logic [ARR_AW-1:0]     arr_rd_addr, arr_wr_addr;
  logic [31:0]           arr_wr_data;

  // Address decode of the live request and of the line being filled.
  always_comb begin
    cur_offset = OFFSET_W'(addr_field(ADDR_MAX'(dcache_addr), 2, OFFSET_W));
    cur_index  = INDEX_W'(addr_field(ADDR_MAX'(dcache_addr), 2 + OFFSET_W, INDEX_W));
    cur_tag    = TAG_W'(addr_field(ADDR_MAX'(dcache_addr), TAG_LSB, TAG_W));
    fill_index = INDEX_W'(addr_field(ADDR_MAX'(mem_req_addr_q), 2 + OFFSET_W, INDEX_W));
    fill_tag   = TAG_W'(addr_field(ADDR_MAX'(mem_req_addr_q), TAG_LSB, TAG_W));
    hit        = valid_q[cur_index] && (tag_mem[cur_index] == cur_tag);
    is_write   = |dcache_we;
    is_read    = !is_write && dcache_re;
  end

  // Next-state, request-channel and array-port logic.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    beat_d          = beat_q;
    wr_done_d       = wr_done_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_rnw_d   = mem_req_rnw_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_data_d  = mem_req_data_q;
    mem_req_be_d    = mem_req_be_q;
    stall           = 1'b0;
    tag_we          = 1'b0;
    arr_rd_en       = 1'b0;
    arr_rd_addr     = {cur_index, cur_offset};
    arr_wr_be       = 4'b0000;
    arr_wr_addr     = {cur_index, cur_offset};
    arr_wr_data     = dcache_din;

    case (state_q)
      ST_IDLE: begin
        wr_done_d = 1'b0;
        if (wr_done_q && is_write) begin
          // The processor is still presenting the write that just completed.
          stall = 1'b0;
        end else if (is_write) begin
          stall           = 1'b1;
          arr_wr_be       = hit ? dcache_we : 4'b0000;
          mem_req_valid_d = 1'b1;
          mem_req_rnw_d   = 1'b0;
          mem_req_addr_d  = ADDR_WIDTH'(word_align(ADDR_MAX'(dcache_addr)));
          mem_req_data_d  = dcache_din;
          mem_req_be_d    = dcache_we;
          state_d         = ST_WR_REQ;
        end else if (is_read) begin
          if (hit) begin
            arr_rd_en = 1'b1;
          end else begin
            stall           = 1'b1;
            mem_req_valid_d = 1'b1;
            mem_req_rnw_d   = 1'b1;
            mem_req_addr_d  = ADDR_WIDTH'(line_align(ADDR_MAX'(dcache_addr), OFFSET_W));
            mem_req_data_d  = '0;
            mem_req_be_d    = '0;
            beat_d          = '0;
            state_d         = ST_FILL_REQ;
          end
        end
      end

      ST_FILL_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_FILL_WAIT;
        end
      end

      ST_FILL_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          arr_wr_be   = 4'b1111;
          arr_wr_addr = {fill_index, beat_q};
          arr_wr_data = mem_resp_data;
          beat_d      = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            tag_we              = 1'b1;
            valid_d[fill_index] = 1'b1;
            state_d             = ST_FILL_DONE;
          end
        end
      end

      ST_FILL_DONE: begin
        arr_rd_en = 1'b1;
        state_d   = ST_IDLE;
      end

      ST_WR_REQ: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          wr_done_d       = 1'b1;
          state_d         = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and request-channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      valid_q         <= '0;
      beat_q          <= '0;
      wr_done_q       <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_rnw_q   <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_data_q  <= '0;
      mem_req_be_q    <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      beat_q          <= beat_d;
      wr_done_q       <= wr_done_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_rnw_q   <= mem_req_rnw_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_data_q  <= mem_req_data_d;
      mem_req_be_q    <= mem_req_be_d;
    end
  end

  // Tag storage; valid bits alone decide whether a tag is meaningful.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[fill_index] <= fill_tag;
    end
  end

  dcache_data_array #(
    .DEPTH(LINES * LINE_WORDS),
    .AW   (ARR_AW)
  ) u_data_array (
    .clk    (clk),
    .rst    (rst),
    .rd_en  (arr_rd_en),
    .rd_addr(arr_rd_addr),
    .rd_data(dcache_dout),
    .wr_be  (arr_wr_be),
    .wr_addr(arr_wr_addr),
    .wr_data(arr_wr_data)
  );

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rnw   = mem_req_rnw_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_data  = mem_req_data_q;
  assign mem_req_be    = mem_req_be_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a small backing-memory model.
module tb_dcache_responder;

  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dcache_addr;
  logic [3:0]  dcache_we;
  logic        dcache_re;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk           (clk),
    .rst           (rst),
    .dcache_addr   (dcache_addr),
    .dcache_we     (dcache_we),
    .dcache_re     (dcache_re),
    .dcache_din    (dcache_din),
    .dcache_dout   (dcache_dout),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_rnw   (mem_req_rnw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_be    (mem_req_be),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backing memory model: default contents {C0DE, addr[15:0]}.
  logic [31:0] bmem [bit [31:0]];
  int ready_delay = 0;
  int beat_gap    = 0;
  int wait_cnt    = 0;
  int beats_left  = 0;
  int beat_idx    = 0;
  int gap_cnt     = 0;
  int fill_cnt    = 0;
  int wr_cnt      = 0;
  int stab_err    = 0;
  bit pend        = 1'b0;
  logic        pend_rnw;
  logic [31:0] pend_addr, pend_data, fill_base, held_addr;
  logic [3:0]  pend_be;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic [3:0]  last_wr_be;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  initial begin
    logic [31:0] w;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      if (pend) begin
        pend = 1'b0;
        if (pend_rnw) begin
          fill_cnt++;
          last_rd_addr = pend_addr;
          fill_base    = pend_addr;
          beats_left   = LINE_WORDS;
          beat_idx     = 0;
          gap_cnt      = 0;
        end else begin
          wr_cnt++;
          last_wr_addr = pend_addr;
          last_wr_data = pend_data;
          last_wr_be   = pend_be;
          w = mem_rd(pend_addr);
          for (int i = 0; i < 4; i++)
            if (pend_be[i]) w[8*i +: 8] = pend_data[8*i +: 8];
          bmem[pend_addr] = w;
        end
      end
      if (beats_left > 0) begin
        if (gap_cnt > 0) begin
          gap_cnt--;
        end else begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_rd(fill_base + 32'(4 * beat_idx));
          beat_idx++;
          beats_left--;
          gap_cnt = beat_gap;
        end
      end else if (mem_req_valid) begin
        if (wait_cnt == 0) held_addr = mem_req_addr;
        else if (mem_req_addr !== held_addr) stab_err++;
        if (wait_cnt >= ready_delay) begin
          mem_req_ready = 1'b1;
          pend      = 1'b1;
          pend_rnw  = mem_req_rnw;
          pend_addr = mem_req_addr;
          pend_data = mem_req_data;
          pend_be   = mem_req_be;
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // One processor access starting at a negedge; returns at the negedge after
  // the access completes, with dcache_dout sampled there.
  task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] din,
                        input logic re, output int stalls, output logic [31:0] rdata);
    dcache_addr = a;
    dcache_we   = we;
    dcache_din  = din;
    dcache_re   = re;
    stalls = 0;
    #1;
    while (stall === 1'b1 && stalls < 100) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 100) chk("stall_timeout", 32'(stall), 32'd0);
    @(negedge clk);
    rdata = dcache_dout;
  endtask

  task automatic idle(input int n);
    dcache_re = 1'b0;
    dcache_we = 4'b0000;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          st;
    int          nb;
    int          cyc;
    logic [31:0] rd;

    bmem[32'h100] = 32'hDEADBEEF;
    rst = 1'b1;
    dcache_addr = '0; dcache_we = '0; dcache_re = 1'b0; dcache_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dcache_dout, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    rst = 1'b0;

    // Cold read miss, then a hit in the same line.
    access(32'h100, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("miss_stalls", st, 6);
    chk("miss_data", rd, 32'hDEADBEEF);
    chk("miss_req_addr", last_rd_addr, 32'h100);
    chk("miss_fills", fill_cnt, 1);
    access(32'h104, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("hit_stalls", st, 0);
    chk("hit_data", rd, 32'hC0DE0104);

    // Partial write to a cached word, then read it back.
    access(32'h104, 4'b0011, 32'h0000ABCD, 1'b0, st, rd);
    chk("wr_stalls", st, 2);
    chk("wr_addr", last_wr_addr, 32'h104);
    chk("wr_be", 32'(last_wr_be), 32'h3);
    chk("wr_data", last_wr_data, 32'h0000ABCD);
    access(32'h104, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("wr_rd_stalls", st, 0);
    chk("wr_rd_data", rd, 32'hC0DEABCD);
    chk("wr_rd_fills", fill_cnt, 1);

    // Write wins when re and we are both set.
    access(32'h108, 4'b1100, 32'h55660000, 1'b1, st, rd);
    chk("prio_stalls", st, 2);
    chk("prio_wr_cnt", wr_cnt, 2);
    access(32'h108, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("prio_rd_stalls", st, 0);
    chk("prio_rd_data", rd, 32'h55660108);
    idle(2);
    chk("idle_hold", dcache_dout, 32'h55660108);

    // Write miss does not allocate; the following read fetches the line.
    access(32'h2000, 4'b1111, 32'h12345678, 1'b0, st, rd);
    chk("wmiss_stalls", st, 2);
    chk("wmiss_fills", fill_cnt, 1);
    access(32'h2000, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("wmiss_rd_stalls", st, 6);
    chk("wmiss_rd_data", rd, 32'h12345678);

    // Conflicting lines on index 0.
    access(32'h000, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("conf0_stalls", st, 6);
    chk("conf0_data", rd, 32'hC0DE0000);
    access(32'h400, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("conf1_stalls", st, 6);
    chk("conf1_data", rd, 32'hC0DE0400);
    access(32'h000, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("conf2_stalls", st, 6);
    chk("conf2_data", rd, 32'hC0DE0000);
    chk("conf_fills", fill_cnt, 5);

    // Slow acceptance and gapped beats.
    ready_delay = 5;
    beat_gap    = 2;
    stab_err    = 0;
    access(32'h808, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("slow_stalls", st, 17);
    chk("slow_data", rd, 32'hC0DE0808);
    chk("slow_req_addr", last_rd_addr, 32'h800);
    chk("slow_stable", stab_err, 0);
    ready_delay = 0;
    beat_gap    = 0;

    // Reset in the middle of a fill, with stray beats afterwards.
    dcache_addr = 32'h500;
    dcache_we   = 4'b0000;
    dcache_re   = 1'b1;
    nb  = 0;
    cyc = 0;
    while (nb < 2 && cyc < 100) begin
      @(posedge clk);
      if (mem_resp_valid) nb++;
      cyc++;
    end
    chk("rst_mid_beats", nb, 2);
    @(negedge clk);
    rst       = 1'b1;
    dcache_re = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_dout", dcache_dout, 32'h0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mid_req_addr", mem_req_addr, 32'h0);
    @(negedge clk);
    idle(3);
    access(32'h500, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("refill_stalls", st, 6);
    chk("refill_data", rd, 32'hC0DE0500);
    access(32'h808, 4'b0000, 32'h0, 1'b1, st, rd);
    chk("post_rst_miss_stalls", st, 6);
    chk("post_rst_miss_data", rd, 32'hC0DE0808);
    chk("final_fills", fill_cnt, 9);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
